// File: rtl/cart_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cart_mem_arbiter
// -----------------------------------------------------------------------------
// Shares the single cartridge SDRAM request port between the ROM loader
// (ioctl write stream) and CPU cartridge reads (slot 1). The T80 is stalled
// through cpu_wait_n_o and the loader through ld_wait_o until each access
// completes. The CPU has priority; a starvation counter guarantees that a
// pending loader write gets through after STARVE_MAX consecutive CPU grants.
//
// Optional feature (compile-time macro CART_ARB_HITCACHE_EN):
//   a 1-entry read cache (address tag, 8-bit data, valid bit). A CPU read
//   that hits is answered from the cache without an SDRAM request.
//   Undefined (default): every CPU read goes to SDRAM.
//
// Parameters
//   ADDR_W      SDRAM byte address width (matches ioctl_addr)
//   STARVE_MAX  consecutive CPU grants allowed while the loader is pending (1..15)
//
// Ports
//   clk_i         system clock (same clock as T80/VDP)
//   reset_n_i     asynchronous reset, active low
//   cpu_rd_i      CPU cartridge read strobe (level)
//   cpu_addr_i    mapped cartridge address, stable while cpu_rd_i=1
//   cpu_q_o       read data to CPU mux (registered)
//   cpu_wait_n_o  0 = stall T80 (combinational so it drops in the edge cycle)
//   ld_wr_i       loader write strobe, 1-cycle pulse
//   ld_addr_i     loader address
//   ld_data_i     loader data
//   ld_wait_o     1 = loader must hold off
//   ld_ovf_o      sticky: loader pulse arrived while ld_wait_o=1
//   mem_req_o     request to SDRAM controller, held until mem_ack_i
//   mem_we_o      1 = write, 0 = read
//   mem_addr_o    access address
//   mem_din_o     write data
//   mem_ack_i     1-cycle completion pulse, read data valid same cycle
//   mem_dout_i    read data
// -----------------------------------------------------------------------------
module cart_mem_arbiter #(
   parameter int ADDR_W     = 25,
   parameter int STARVE_MAX = 8
) (
   input  logic              clk_i,
   input  logic              reset_n_i,
   input  logic              cpu_rd_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   output logic [7:0]        cpu_q_o,
   output logic              cpu_wait_n_o,
   input  logic              ld_wr_i,
   input  logic [ADDR_W-1:0] ld_addr_i,
   input  logic [7:0]        ld_data_i,
   output logic              ld_wait_o,
   output logic              ld_ovf_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [7:0]        mem_din_o,
   input  logic              mem_ack_i,
   input  logic [7:0]        mem_dout_i
);

   localparam logic [3:0] STARVE_LIM_C = 4'(STARVE_MAX);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_GRANT_CPU = 2'd1,
      ST_GRANT_LD  = 2'd2,
      ST_WAIT_ACK  = 2'd3
   } state_t;

   state_t              state_r;
   state_t              state_nxt_s;

   logic                cpu_rd_r;
   logic                cpu_rise_s;
   logic                cpu_pend_r;
   logic [ADDR_W-1:0]   cpu_addr_r;
   logic [7:0]          cpu_q_r;

   logic                ld_pend_r;
   logic                ld_ovf_r;
   logic [ADDR_W-1:0]   ld_addr_r;
   logic [7:0]          ld_data_r;
   logic                ld_accept_s;
   logic                ld_drop_s;

   logic [3:0]          starve_r;
   logic                own_cpu_r;

   logic                mem_req_r;
   logic                mem_we_r;
   logic [ADDR_W-1:0]   mem_addr_r;
   logic [7:0]          mem_din_r;

   logic                gnt_cpu_s;
   logic                gnt_ld_s;
   logic                issue_cpu_s;
   logic                issue_ld_s;
   logic                ack_s;
   logic                cpu_ack_s;
   logic                ld_ack_s;

   logic                hit_s;
   logic [7:0]          cache_data_s;

   assign cpu_rise_s   = cpu_rd_i & ~cpu_rd_r;
   assign ld_accept_s  = ld_wr_i & ~ld_pend_r;
   assign ld_drop_s    = ld_wr_i & ld_pend_r;

   // An ack only counts while an access is outstanding; stray acks are ignored.
   assign ack_s        = (state_r == ST_WAIT_ACK) & mem_ack_i;
   assign cpu_ack_s    = ack_s & own_cpu_r;
   assign ld_ack_s     = ack_s & ~own_cpu_r;

   assign cpu_wait_n_o = ~(cpu_rise_s | cpu_pend_r);
   assign cpu_q_o      = cpu_q_r;
   assign ld_wait_o    = ld_pend_r;
   assign ld_ovf_o     = ld_ovf_r;
   assign mem_req_o    = mem_req_r;
   assign mem_we_o     = mem_we_r;
   assign mem_addr_o   = mem_addr_r;
   assign mem_din_o    = mem_din_r;

   // FSM state register
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state decision; CPU wins unless the loader has been starved
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (cpu_pend_r && (starve_r < STARVE_LIM_C)) begin
               state_nxt_s = ST_GRANT_CPU;
            end else if (ld_pend_r) begin
               state_nxt_s = ST_GRANT_LD;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_GRANT_CPU: state_nxt_s = ST_WAIT_ACK;
         ST_GRANT_LD:  state_nxt_s = ST_WAIT_ACK;
         ST_WAIT_ACK: begin
            if (mem_ack_i) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_WAIT_ACK;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM output strobes: IDLE grant decisions and grant-cycle issue pulses
   always_comb begin
      gnt_cpu_s   = 1'b0;
      gnt_ld_s    = 1'b0;
      issue_cpu_s = 1'b0;
      issue_ld_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            gnt_cpu_s = (state_nxt_s == ST_GRANT_CPU);
            gnt_ld_s  = (state_nxt_s == ST_GRANT_LD);
         end
         ST_GRANT_CPU: issue_cpu_s = 1'b1;
         ST_GRANT_LD:  issue_ld_s  = 1'b1;
         ST_WAIT_ACK: begin
            issue_cpu_s = 1'b0;
         end
         default: begin
            issue_ld_s = 1'b0;
         end
      endcase
   end

   // CPU read capture; a rise in the ack cycle keeps the request pending
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         cpu_rd_r   <= 1'b0;
         cpu_pend_r <= 1'b0;
         cpu_addr_r <= '0;
      end else begin
         cpu_rd_r <= cpu_rd_i;
         if (cpu_rise_s && !hit_s) begin
            cpu_pend_r <= 1'b1;
            cpu_addr_r <= cpu_addr_i;
         end else if (cpu_ack_s) begin
            cpu_pend_r <= 1'b0;
         end else begin
            cpu_pend_r <= cpu_pend_r;
         end
      end
   end

   // CPU read data register; a cache hit answers the newest read
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         cpu_q_r <= 8'hFF;
      end else if (hit_s) begin
         cpu_q_r <= cache_data_s;
      end else if (cpu_ack_s) begin
         cpu_q_r <= mem_dout_i;
      end else begin
         cpu_q_r <= cpu_q_r;
      end
   end

   // Loader capture: one outstanding write, extra pulses are dropped and flagged
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         ld_pend_r <= 1'b0;
         ld_ovf_r  <= 1'b0;
         ld_addr_r <= '0;
         ld_data_r <= 8'h00;
      end else begin
         if (ld_accept_s) begin
            ld_pend_r <= 1'b1;
            ld_addr_r <= ld_addr_i;
            ld_data_r <= ld_data_i;
         end else if (ld_ack_s) begin
            ld_pend_r <= 1'b0;
         end else begin
            ld_pend_r <= ld_pend_r;
         end
         if (ld_drop_s) begin
            ld_ovf_r <= 1'b1;
         end else begin
            ld_ovf_r <= ld_ovf_r;
         end
      end
   end

   // Starvation counter: counts CPU grants taken while the loader waits
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         starve_r <= 4'd0;
      end else if (gnt_ld_s || !ld_pend_r) begin
         starve_r <= 4'd0;
      end else if (gnt_cpu_s && (starve_r < STARVE_LIM_C)) begin
         starve_r <= starve_r + 4'd1;
      end else begin
         starve_r <= starve_r;
      end
   end

   // SDRAM request registers, loaded in the grant cycle and held until ack
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         mem_req_r  <= 1'b0;
         mem_we_r   <= 1'b0;
         mem_addr_r <= '0;
         mem_din_r  <= 8'h00;
         own_cpu_r  <= 1'b0;
      end else if (issue_cpu_s) begin
         mem_req_r  <= 1'b1;
         mem_we_r   <= 1'b0;
         mem_addr_r <= cpu_addr_r;
         own_cpu_r  <= 1'b1;
      end else if (issue_ld_s) begin
         mem_req_r  <= 1'b1;
         mem_we_r   <= 1'b1;
         mem_addr_r <= ld_addr_r;
         mem_din_r  <= ld_data_r;
         own_cpu_r  <= 1'b0;
      end else if (ack_s) begin
         mem_req_r  <= 1'b0;
      end else begin
         mem_req_r  <= mem_req_r;
      end
   end

`ifdef CART_ARB_HITCACHE_EN
   logic                cache_vld_r;
   logic [ADDR_W-1:0]   cache_tag_r;
   logic [7:0]          cache_dat_r;

   assign hit_s        = cpu_rise_s & cache_vld_r & (cache_tag_r == cpu_addr_i);
   assign cache_data_s = cache_dat_r;

   // Read cache: filled on every CPU ack, invalidated by any loader grant
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         cache_vld_r <= 1'b0;
         cache_tag_r <= '0;
         cache_dat_r <= 8'h00;
      end else if (issue_ld_s) begin
         cache_vld_r <= 1'b0;
      end else if (cpu_ack_s) begin
         cache_vld_r <= 1'b1;
         cache_tag_r <= mem_addr_r;
         cache_dat_r <= mem_dout_i;
      end else begin
         cache_vld_r <= cache_vld_r;
      end
   end
`else
   assign hit_s        = 1'b0;
   assign cache_data_s = 8'hFF;
`endif

endmodule

// File: tb/tb_cart_mem_arbiter.sv
module tb_cart_mem_arbiter;

   localparam int ADDR_W = 25;

   logic              clk_i = 1'b0;
   logic              reset_n_i = 1'b0;
   logic              cpu_rd_i = 1'b0;
   logic [ADDR_W-1:0] cpu_addr_i = '0;
   logic [7:0]        cpu_q_o;
   logic              cpu_wait_n_o;
   logic              ld_wr_i = 1'b0;
   logic [ADDR_W-1:0] ld_addr_i = '0;
   logic [7:0]        ld_data_i = 8'h00;
   logic              ld_wait_o;
   logic              ld_ovf_o;
   logic              mem_req_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [7:0]        mem_din_o;
   logic              mem_ack_i = 1'b0;
   logic [7:0]        mem_dout_i = 8'h00;

   int checks = 0;
   int failures = 0;

   always #5 clk_i = ~clk_i;

   cart_mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(8)) dut (
      .clk_i        (clk_i),
      .reset_n_i    (reset_n_i),
      .cpu_rd_i     (cpu_rd_i),
      .cpu_addr_i   (cpu_addr_i),
      .cpu_q_o      (cpu_q_o),
      .cpu_wait_n_o (cpu_wait_n_o),
      .ld_wr_i      (ld_wr_i),
      .ld_addr_i    (ld_addr_i),
      .ld_data_i    (ld_data_i),
      .ld_wait_o    (ld_wait_o),
      .ld_ovf_o     (ld_ovf_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_din_o    (mem_din_o),
      .mem_ack_i    (mem_ack_i),
      .mem_dout_i   (mem_dout_i)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_i);
   endtask

   // wait (bounded) for a request; leaves the bench at a negedge with mem_req_o=1
   task automatic wait_req(input string tag);
      int n;
      n = 0;
      while (mem_req_o !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      chk(tag, {63'd0, mem_req_o}, 64'd1);
   endtask

   task automatic serve(input logic [7:0] rdata, input int delay);
      repeat (delay) tick();
      mem_dout_i = rdata;
      mem_ack_i  = 1'b1;
      tick();
      mem_ack_i  = 1'b0;
   endtask

   task automatic no_req(input string tag, input int cycles);
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < cycles; k++) begin
         tick();
         if (mem_req_o !== 1'b0) seen = 1'b1;
      end
      chk(tag, {63'd0, seen}, 64'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int cpu_cnt;
      int rounds;
      logic need_pulse;
      logic [ADDR_W-1:0] a;

      // ---- 1: reset values, then quiet for 100 cycles
      repeat (3) tick();
      chk("rst_cpu_q",    {56'd0, cpu_q_o}, 64'hFF);
      chk("rst_wait_n",   {63'd0, cpu_wait_n_o}, 64'd1);
      chk("rst_ld_wait",  {63'd0, ld_wait_o}, 64'd0);
      chk("rst_ld_ovf",   {63'd0, ld_ovf_o}, 64'd0);
      chk("rst_mem_req",  {63'd0, mem_req_o}, 64'd0);
      chk("rst_mem_we",   {63'd0, mem_we_o}, 64'd0);
      chk("rst_mem_addr", {39'd0, mem_addr_o}, 64'd0);
      chk("rst_mem_din",  {56'd0, mem_din_o}, 64'd0);
      reset_n_i = 1'b1;
      no_req("idle_no_req", 100);

      // ---- 2: single CPU read, SDRAM returns 3C after 5 cycles
      cpu_addr_i = 25'h0004000;
      cpu_rd_i   = 1'b1;
      #1;
      chk("t2_wait_edge", {63'd0, cpu_wait_n_o}, 64'd0);
      tick();
      chk("t2_wait_pend", {63'd0, cpu_wait_n_o}, 64'd0);
      wait_req("t2_req");
      chk("t2_we",   {63'd0, mem_we_o}, 64'd0);
      chk("t2_addr", {39'd0, mem_addr_o}, 64'h4000);
      repeat (5) tick();
      chk("t2_req_held", {63'd0, mem_req_o}, 64'd1);
      chk("t2_wait_held", {63'd0, cpu_wait_n_o}, 64'd0);
      serve(8'h3C, 0);
      chk("t2_cpu_q",   {56'd0, cpu_q_o}, 64'h3C);
      chk("t2_wait_rel", {63'd0, cpu_wait_n_o}, 64'd1);
      chk("t2_req_drop", {63'd0, mem_req_o}, 64'd0);
      cpu_rd_i = 1'b0;
      tick();

      // ---- 3: loader stream 0x00..0xFF
      for (int i = 0; i < 256; i++) begin
         int n;
         n = 0;
         while (ld_wait_o !== 1'b0 && n < 50) begin
            tick();
            n++;
         end
         ld_addr_i = 25'(i);
         ld_data_i = 8'(i);
         ld_wr_i   = 1'b1;
         tick();
         ld_wr_i   = 1'b0;
         wait_req("t3_req");
         chk("t3_wr", {30'd0, mem_we_o, mem_addr_o, mem_din_o}, {30'd0, 1'b1, 25'(i), 8'(i)});
         serve(8'h00, 0);
      end
      chk("t3_ovf", {63'd0, ld_ovf_o}, 64'd0);
      tick();
      chk("t3_ld_wait_end", {63'd0, ld_wait_o}, 64'd0);

      // ---- 5: second pulse while busy is dropped and sets sticky overflow
      ld_addr_i = 25'h0001234;
      ld_data_i = 8'hAA;
      ld_wr_i   = 1'b1;
      tick();
      chk("t5_ld_wait", {63'd0, ld_wait_o}, 64'd1);
      ld_addr_i = 25'h0005678;
      ld_data_i = 8'h55;
      tick();
      ld_wr_i = 1'b0;
      chk("t5_ovf_set", {63'd0, ld_ovf_o}, 64'd1);
      wait_req("t5_req");
      chk("t5_addr", {39'd0, mem_addr_o}, 64'h1234);
      chk("t5_din",  {56'd0, mem_din_o}, 64'hAA);
      serve(8'h00, 0);
      chk("t5_ld_wait_rel", {63'd0, ld_wait_o}, 64'd0);
      chk("t5_ovf_sticky",  {63'd0, ld_ovf_o}, 64'd1);
      no_req("t5_dropped_no_req", 10);

      // ---- 4: continuous CPU reads with loader pending -> 8 CPU grants, then loader
      a          = 25'h0010000;
      cpu_addr_i = a;
      cpu_rd_i   = 1'b1;
      ld_addr_i  = 25'h0000100;
      ld_data_i  = 8'h77;
      ld_wr_i    = 1'b1;
      #1;
      chk("t4_wait_edge", {63'd0, cpu_wait_n_o}, 64'd0);
      tick();
      ld_wr_i = 1'b0;
      chk("t4_both_ld", {63'd0, ld_wait_o}, 64'd1);
      chk("t4_both_cpu", {63'd0, cpu_wait_n_o}, 64'd0);
      cpu_cnt    = 0;
      rounds     = 0;
      need_pulse = 1'b0;
      for (int g = 0; g < 40 && rounds < 2; g++) begin
         wait_req("t4_req");
         if (mem_we_o === 1'b0) begin
            if (need_pulse) begin
               ld_addr_i  = 25'h0000200;
               ld_wr_i    = 1'b1;
               need_pulse = 1'b0;
               cpu_cnt    = 0;
            end else begin
               cpu_cnt++;
            end
            cpu_rd_i   = 1'b0;
            a          = a + 25'd1;
            cpu_addr_i = a;
            tick();
            ld_wr_i    = 1'b0;
            cpu_rd_i   = 1'b1;
            mem_dout_i = 8'h11;
            mem_ack_i  = 1'b1;
            tick();
            mem_ack_i  = 1'b0;
         end else begin
            chk("t4_cpu_grants_before_ld", 64'(cpu_cnt), 64'd8);
            rounds++;
            serve(8'h00, 0);
            need_pulse = 1'b1;
         end
      end
      chk("t4_rounds", 64'(rounds), 64'd2);
      wait_req("t4_tail_req");
      chk("t4_tail_we", {63'd0, mem_we_o}, 64'd0);
      cpu_rd_i   = 1'b0;
      mem_dout_i = 8'h11;
      mem_ack_i  = 1'b1;
      tick();
      mem_ack_i  = 1'b0;
      tick();
      chk("t4_tail_wait", {63'd0, cpu_wait_n_o}, 64'd1);
      chk("t4_tail_q",    {56'd0, cpu_q_o}, 64'h11);

      // ---- 6: reset during WAIT_ACK, late ack afterwards is ignored
      cpu_addr_i = 25'h000ABCD;
      cpu_rd_i   = 1'b1;
      tick();
      wait_req("t6_req");
      tick();
      reset_n_i = 1'b0;
      cpu_rd_i  = 1'b0;
      #1;
      chk("t6_rst_req",  {63'd0, mem_req_o}, 64'd0);
      chk("t6_rst_q",    {56'd0, cpu_q_o}, 64'hFF);
      chk("t6_rst_wait", {63'd0, cpu_wait_n_o}, 64'd1);
      chk("t6_rst_ovf",  {63'd0, ld_ovf_o}, 64'd0);
      tick();
      tick();
      reset_n_i = 1'b1;
      tick();
      serve(8'hA5, 0);
      chk("t6_late_ack_q",   {56'd0, cpu_q_o}, 64'hFF);
      chk("t6_late_ack_req", {63'd0, mem_req_o}, 64'd0);
      chk("t6_late_ack_wait", {63'd0, cpu_wait_n_o}, 64'd1);
      no_req("t6_fsm_idle", 10);

`ifdef CART_ARB_HITCACHE_EN
      // ---- 7: cache hit avoids SDRAM, loader write invalidates
      cpu_addr_i = 25'h0004000;
      cpu_rd_i   = 1'b1;
      tick();
      wait_req("t7_miss_req");
      serve(8'h5A, 1);
      chk("t7_miss_q", {56'd0, cpu_q_o}, 64'h5A);
      cpu_rd_i = 1'b0;
      tick();
      cpu_rd_i = 1'b1;
      #1;
      chk("t7_hit_wait_edge", {63'd0, cpu_wait_n_o}, 64'd0);
      tick();
      chk("t7_hit_wait_rel", {63'd0, cpu_wait_n_o}, 64'd1);
      chk("t7_hit_q", {56'd0, cpu_q_o}, 64'h5A);
      no_req("t7_hit_no_req", 10);
      cpu_rd_i  = 1'b0;
      ld_addr_i = 25'h0000300;
      ld_data_i = 8'h01;
      ld_wr_i   = 1'b1;
      tick();
      ld_wr_i = 1'b0;
      wait_req("t7_ld_req");
      serve(8'h00, 0);
      cpu_rd_i = 1'b1;
      tick();
      wait_req("t7_after_ld_req");
      chk("t7_after_ld_we", {63'd0, mem_we_o}, 64'd0);
      serve(8'h6B, 0);
      chk("t7_after_ld_q", {56'd0, cpu_q_o}, 64'h6B);
      cpu_rd_i = 1'b0;
      tick();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
